// File: rtl/floo_wormhole_arbiter.sv
// Round-robin wormhole arbiter: shares one valid/ready channel among NumInp requesters.
// Packets are never interleaved; zero-latency combinational datapath.
module floo_wormhole_arbiter #(
  parameter int unsigned NumInp    = 4,
  parameter int unsigned DataWidth = 64,
  localparam int unsigned SelW     = (NumInp > 1) ? $clog2(NumInp) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumInp-1:0]             valid_i,
  output logic [NumInp-1:0]             ready_o,
  input  logic [NumInp*DataWidth-1:0]   data_i,
  input  logic [NumInp-1:0]             last_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [DataWidth-1:0]          data_o,
  output logic                          last_o,
  output logic [SelW-1:0]               sel_o
);

  logic [SelW-1:0] rr_q, rr_d;
  logic [SelW-1:0] idx_q, idx_d;
  logic            lock_q, lock_d;
  logic [SelW-1:0] grant;
  logic [SelW-1:0] cand;
  logic            found;

  // Grant selection: locked index wins outright, else first valid at/after rr pointer.
  always_comb begin
    grant = rr_q;
    cand  = '0;
    found = 1'b0;
    if (lock_q) begin
      grant = idx_q;
      found = valid_i[idx_q];
    end else begin
      for (int unsigned i = 0; i < NumInp; i++) begin
        cand = SelW'((32'(rr_q) + i) % NumInp);
        if (!found && valid_i[cand]) begin
          found = 1'b1;
          grant = cand;
        end
      end
    end
  end

  always_comb begin
    ready_o = '0;
    valid_o = found;
    data_o  = '0;
    last_o  = 1'b0;
    sel_o   = rr_q;
    // A locked requester keeps its ready path even while it has no beat to offer.
    if (NumInp == 1 || lock_q || found) ready_o[grant] = ready_i;
    if (found) begin
      data_o = data_i[32'(grant)*DataWidth +: DataWidth];
      last_o = last_i[grant];
      sel_o  = grant;
    end
  end

  always_comb begin
    rr_d   = rr_q;
    idx_d  = idx_q;
    lock_d = lock_q;
    if (found) begin
      if (ready_i && last_i[grant]) begin
        lock_d = 1'b0;
        rr_d   = (grant == SelW'(NumInp - 1)) ? '0 : grant + SelW'(1);
      end else begin
        // Mid-packet beat or stalled beat: pin the grant until the tail is accepted.
        lock_d = 1'b1;
        idx_d  = grant;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q   <= '0;
      idx_q  <= '0;
      lock_q <= 1'b0;
    end else begin
      rr_q   <= rr_d;
      idx_q  <= idx_d;
      lock_q <= lock_d;
    end
  end

endmodule

// File: tb/tb_floo_wormhole_arbiter.sv
// Directed bench for floo_wormhole_arbiter: stimulus pushes expected per-cycle outputs,
// a negedge monitor pops and compares them.
module tb_floo_wormhole_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      valid_i = '0;
  logic [N-1:0]      ready_o;
  logic [N*DW-1:0]   data_i;
  logic [N-1:0]      last_i = '0;
  logic              valid_o;
  logic              ready_i = 1'b0;
  logic [DW-1:0]     data_o;
  logic              last_o;
  logic [1:0]        sel_o;

  typedef struct {
    int          tag;
    logic        valid;
    logic [1:0]  sel;
    logic [63:0] data;
    logic        last;
    logic [3:0]  rdy;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          tag    = 0;
  logic [63:0] dt [N];

  always #5 clk = ~clk;

  assign data_i = {dt[3], dt[2], dt[1], dt[0]};

  floo_wormhole_arbiter #(.NumInp(N), .DataWidth(DW)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .last_i  (last_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .last_o  (last_o),
    .sel_o   (sel_o)
  );

  task automatic chk(input string name, input int t, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s step=%0d got=%h expected=%h", name, t, got, want);
    end
  endtask

  // Drive one cycle of inputs and record the hand-derived outputs for that cycle.
  task automatic step(input logic [3:0] v, input logic [3:0] l, input logic r,
                      input logic ev, input logic [1:0] es, input logic el, input logic [3:0] erdy);
    exp_t e;
    @(posedge clk);
    #1;
    valid_i = v;
    last_i  = l;
    ready_i = r;
    tag++;
    e.tag   = tag;
    e.valid = ev;
    e.sel   = es;
    e.data  = ev ? dt[es] : 64'h0;
    e.last  = el;
    e.rdy   = erdy;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("valid_o", e.tag, 64'(valid_o), 64'(e.valid));
        chk("sel_o",   e.tag, 64'(sel_o),   64'(e.sel));
        chk("data_o",  e.tag, data_o,       e.data);
        chk("last_o",  e.tag, 64'(last_o),  64'(e.last));
        chk("ready_o", e.tag, 64'(ready_o), 64'(e.rdy));
      end
    end
  end

  initial begin : stim
    dt[0] = 64'h0000_0000_0000_00D0;
    dt[1] = 64'h0000_0000_0000_00A5;
    dt[2] = 64'hDEAD_BEEF_0000_0002;
    dt[3] = 64'hCAFE_0000_0000_0003;

    // Held in reset: outputs follow inputs with pointer 0, state frozen
    step(4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100);
    step(4'b1001, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0001);
    step(4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000);
    @(negedge clk); #2 rst_n = 1'b1;

    // Round robin over single-beat packets
    step(4'b1111, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001);
    step(4'b1111, 4'b1111, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010);
    step(4'b1111, 4'b1111, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100);
    step(4'b1111, 4'b1111, 1'b1, 1'b1, 2'd3, 1'b1, 4'b1000);
    step(4'b1111, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001); // ptr -> 1

    // Packet lock: input 2 three beats, input 0 waits
    step(4'b0101, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b0, 4'b0100);
    step(4'b0101, 4'b0001, 1'b1, 1'b1, 2'd2, 1'b0, 4'b0100);
    step(4'b0101, 4'b0101, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100); // ptr -> 3
    step(4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001); // ptr -> 1

    // Idle: nothing granted, sel_o shows pointer, any ready_i
    step(4'b0000, 4'b1111, 1'b1, 1'b0, 2'd1, 1'b0, 4'b0000);
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0, 4'b0000);

    // Backpressure: input 1 stalls, input 0 arrives late
    step(4'b0010, 4'b0010, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0000);
    step(4'b0011, 4'b0011, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0000);
    step(4'b0011, 4'b0011, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0000);
    step(4'b0011, 4'b0011, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010); // ptr -> 2
    step(4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001); // ptr -> 1

    // Wrap-around from pointer 3
    step(4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100); // ptr -> 3
    step(4'b1010, 4'b1010, 1'b1, 1'b1, 2'd3, 1'b1, 4'b1000); // ptr -> 0
    step(4'b1010, 4'b1010, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010); // ptr -> 2

    // Locked requester drops valid: no beat, others still blocked
    step(4'b0001, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0001);
    step(4'b0100, 4'b0100, 1'b1, 1'b0, 2'd2, 1'b0, 4'b0001);
    step(4'b0101, 4'b0101, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001); // ptr -> 1

    // Reset mid-packet: input 3 locked, async pulse between edges
    step(4'b1000, 4'b0000, 1'b1, 1'b1, 2'd3, 1'b0, 4'b1000);
    @(negedge clk);
    #1 valid_i = '0;
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step(4'b1001, 4'b1001, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001); // ptr -> 1
    step(4'b1000, 4'b1000, 1'b1, 1'b1, 2'd3, 1'b1, 4'b1000); // ptr -> 0
    step(4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
